pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage pipeline. It generates enable, flush and bubble controls for the IF/ID and ID/EX pipeline registers and a shared enable for the EX/MEM and MEM/WB registers. It also produces operand forwarding selects for the EX stage and runs the halt-drain state machine. It sits beside the ID stage and takes register addresses and control bits from ID, EX, MEM and WB.

---
 rtl/pipeline_ctrl_pkg.sv | 16 +
 rtl/pipeline_ctrl_forwarding_unit.sv | 38 +++
 rtl/pipeline_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam int unsigned DRAIN_DEPTH = 3;

endpackage

// File: rtl/pipeline_ctrl_forwarding_unit.sv
// EX operand forwarding selects; MEM result beats WB result, r0 never forwards.
module forwarding_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] i_ex_rs1,
    input  logic [REG_W-1:0] i_ex_rs2,
    input  logic             i_mem_reg_wrenable,
    input  logic [REG_W-1:0] i_mem_write_reg,
    input  logic             i_wb_reg_wrenable,
    input  logic [REG_W-1:0] i_wb_write_reg,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel
);

    logic w_mem_valid;
    logic w_wb_valid;

    assign w_mem_valid = i_mem_reg_wrenable && (i_mem_write_reg != '0);
    assign w_wb_valid  = i_wb_reg_wrenable  && (i_wb_write_reg  != '0);

    always_comb begin
        o_fwd_a_sel = FWD_RF;
        o_fwd_b_sel = FWD_RF;
        if (w_mem_valid && (i_mem_write_reg == i_ex_rs1)) begin
            o_fwd_a_sel = FWD_MEM;
        end else if (w_wb_valid && (i_wb_write_reg == i_ex_rs1)) begin
            o_fwd_a_sel = FWD_WB;
        end
        if (w_mem_valid && (i_mem_write_reg == i_ex_rs2)) begin
            o_fwd_b_sel = FWD_MEM;
        end else if (w_wb_valid && (i_wb_write_reg == i_ex_rs2)) begin
            o_fwd_b_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and halt-drain controller for the 5-stage pipeline.
// Control outputs are combinational; state, drain count and stall counter are registered.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_halt,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic             ex_reg_wrenable,
    input  logic             ex_mem_to_reg,
    input  logic [REG_W-1:0] ex_write_reg,
    input  logic             ex_branch_taken,
    input  logic             mem_reg_wrenable,
    input  logic [REG_W-1:0] mem_write_reg,
    input  logic             wb_reg_wrenable,
    input  logic [REG_W-1:0] wb_write_reg,
    input  logic             mem_busy,
    output logic             pc_enable,
    output logic             ifid_enable,
    output logic             ifid_flush,
    output logic             idex_enable,
    output logic             idex_bubble,
    output logic             pipe_enable,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    state_e           r_state;
    logic [1:0]       r_drain_cnt;
    logic [CNT_W-1:0] r_stall_cycles;

    logic       w_load_use;
    logic       w_stall_event;
    logic       w_halt_accept;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    forwarding_unit #(.REG_W(REG_W)) u_fwd (
        .i_ex_rs1           (ex_rs1),
        .i_ex_rs2           (ex_rs2),
        .i_mem_reg_wrenable (mem_reg_wrenable),
        .i_mem_write_reg    (mem_write_reg),
        .i_wb_reg_wrenable  (wb_reg_wrenable),
        .i_wb_write_reg     (wb_write_reg),
        .o_fwd_a_sel        (w_fwd_a),
        .o_fwd_b_sel        (w_fwd_b)
    );

    assign w_load_use = ex_mem_to_reg && ex_reg_wrenable && (ex_write_reg != '0) &&
                        ((id_uses_rs1 && (id_rs1 == ex_write_reg)) ||
                         (id_uses_rs2 && (id_rs2 == ex_write_reg)));

    // A taken branch squashes the ID instruction, so its load-use does not stall.
    always_comb begin
        w_stall_event = 1'b0;
        unique case (r_state)
            RUN:     w_stall_event = mem_busy || (!ex_branch_taken && w_load_use);
            DRAIN:   w_stall_event = mem_busy || w_load_use;
            default: w_stall_event = 1'b0;
        endcase
    end

    assign w_halt_accept = (r_state == RUN) && !mem_busy && !ex_branch_taken &&
                           !w_load_use && id_halt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= RUN;
            r_drain_cnt    <= 2'd0;
            r_stall_cycles <= '0;
        end else begin
            if (w_stall_event && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            unique case (r_state)
                RUN: begin
                    if (w_halt_accept) begin
                        r_state     <= DRAIN;
                        r_drain_cnt <= 2'(DRAIN_DEPTH);
                    end
                end
                DRAIN: begin
                    if (!mem_busy) begin
                        r_drain_cnt <= r_drain_cnt - 2'd1;
                        if (r_drain_cnt == 2'd1) begin
                            r_state <= HALTED;
                        end
                    end
                end
                default: r_state <= HALTED;
            endcase
        end
    end

    always_comb begin
        pc_enable   = 1'b0;
        ifid_enable = 1'b0;
        ifid_flush  = 1'b0;
        idex_enable = 1'b0;
        idex_bubble = 1'b0;
        pipe_enable = 1'b0;
        if (reset) begin
            ifid_enable = 1'b1;
            ifid_flush  = 1'b1;
            idex_enable = 1'b1;
            idex_bubble = 1'b1;
            pipe_enable = 1'b1;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (!mem_busy) begin
                        pc_enable   = !w_load_use || ex_branch_taken;
                        ifid_enable = !w_load_use || ex_branch_taken;
                        ifid_flush  = ex_branch_taken;
                        idex_enable = 1'b1;
                        idex_bubble = ex_branch_taken || w_load_use;
                        pipe_enable = 1'b1;
                    end
                end
                // Younger instructions behind the halt are squashed while it drains.
                DRAIN: begin
                    if (!mem_busy) begin
                        ifid_enable = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_enable = 1'b1;
                        idex_bubble = 1'b1;
                        pipe_enable = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign halted       = !reset && (r_state == HALTED);
    assign stall_cycles = reset ? '0 : r_stall_cycles;
    assign fwd_a_sel    = reset ? FWD_RF : w_fwd_a;
    assign fwd_b_sel    = reset ? FWD_RF : w_fwd_b;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, corner sequences, random vs. model.
module tb_pipeline_ctrl;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned CNT_W   = 16;
    localparam int          CNT_MAX = 65535;

    typedef struct {
        logic             reset;
        logic [REG_W-1:0] id_rs1, id_rs2;
        logic             id_u1, id_u2, id_halt;
        logic [REG_W-1:0] ex_rs1, ex_rs2;
        logic             ex_we, ex_load;
        logic [REG_W-1:0] ex_wr;
        logic             br;
        logic             mem_we;
        logic [REG_W-1:0] mem_wr;
        logic             wb_we;
        logic [REG_W-1:0] wb_wr;
        logic             busy;
    } in_t;

    typedef struct packed {
        logic       pc, ife, ifl, ide, bub, pipe;
        logic [1:0] fa, fb;
        logic       hlt;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_write_reg, mem_write_reg, wb_write_reg;
    logic id_uses_rs1, id_uses_rs2, id_halt, ex_reg_wrenable, ex_mem_to_reg, ex_branch_taken;
    logic mem_reg_wrenable, wb_reg_wrenable, mem_busy;
    logic pc_enable, ifid_enable, ifid_flush, idex_enable, idex_bubble, pipe_enable, halted;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: halt flag, cycles of drain still owed, total stall count.
    bit m_halted    = 1'b0;
    int m_drain_left = 0;
    int m_stall     = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_halt(id_halt), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_reg_wrenable(ex_reg_wrenable),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_write_reg(ex_write_reg), .ex_branch_taken(ex_branch_taken),
        .mem_reg_wrenable(mem_reg_wrenable), .mem_write_reg(mem_write_reg),
        .wb_reg_wrenable(wb_reg_wrenable), .wb_write_reg(wb_write_reg), .mem_busy(mem_busy),
        .pc_enable(pc_enable), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
        .idex_enable(idex_enable), .idex_bubble(idex_bubble), .pipe_enable(pipe_enable),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .halted(halted), .stall_cycles(stall_cycles)
    );

    function automatic in_t idle();
        in_t v;
        v.reset = 1'b0; v.id_rs1 = '0; v.id_rs2 = '0; v.id_u1 = 1'b0; v.id_u2 = 1'b0;
        v.id_halt = 1'b0; v.ex_rs1 = '0; v.ex_rs2 = '0; v.ex_we = 1'b0; v.ex_load = 1'b0;
        v.ex_wr = '0; v.br = 1'b0; v.mem_we = 1'b0; v.mem_wr = '0; v.wb_we = 1'b0;
        v.wb_wr = '0; v.busy = 1'b0;
        return v;
    endfunction

    function automatic out_t mk(logic pc, logic ife, logic ifl, logic ide, logic bub, logic pipe,
                                logic [1:0] fa, logic [1:0] fb, logic hlt);
        out_t o;
        o.pc = pc; o.ife = ife; o.ifl = ifl; o.ide = ide; o.bub = bub; o.pipe = pipe;
        o.fa = fa; o.fb = fb; o.hlt = hlt;
        return o;
    endfunction

    // The ID instruction needs a value a load in EX has not produced yet.
    function automatic bit needs_loaded_value(in_t v);
        bit is_load = v.ex_load && v.ex_we && (v.ex_wr != 0);
        return is_load && ((v.id_u1 && v.id_rs1 == v.ex_wr) || (v.id_u2 && v.id_rs2 == v.ex_wr));
    endfunction

    function automatic logic [1:0] src_of(logic [REG_W-1:0] r, in_t v);
        if (r != 0 && v.mem_we && v.mem_wr == r) return 2'd1;
        if (r != 0 && v.wb_we && v.wb_wr == r) return 2'd2;
        return 2'd0;
    endfunction

    function automatic out_t model_out(in_t v);
        logic [1:0] fa = src_of(v.ex_rs1, v);
        logic [1:0] fb = src_of(v.ex_rs2, v);
        if (v.reset)            return mk(0, 1, 1, 1, 1, 1, 0, 0, 0);
        if (m_halted)           return mk(0, 0, 0, 0, 0, 0, fa, fb, 1);
        if (v.busy)             return mk(0, 0, 0, 0, 0, 0, fa, fb, 0);
        if (m_drain_left > 0)   return mk(0, 1, 1, 1, 1, 1, fa, fb, 0);
        if (v.br)               return mk(1, 1, 1, 1, 1, 1, fa, fb, 0);
        if (needs_loaded_value(v)) return mk(0, 0, 0, 1, 1, 1, fa, fb, 0);
        return mk(1, 1, 0, 1, 0, 1, fa, fb, 0);
    endfunction

    // The bubble during an unfrozen drain is left unchecked.
    function automatic out_t model_mask(in_t v);
        out_t m = '1;
        if (!v.reset && !m_halted && !v.busy && m_drain_left > 0) m.bub = 1'b0;
        return m;
    endfunction

    function automatic void model_update(in_t v);
        bit stalled;
        if (v.reset) begin
            m_halted = 1'b0; m_drain_left = 0; m_stall = 0;
        end else if (!m_halted) begin
            if (m_drain_left > 0) begin
                stalled = v.busy || needs_loaded_value(v);
                if (!v.busy) begin
                    m_drain_left--;
                    if (m_drain_left == 0) m_halted = 1'b1;
                end
            end else begin
                stalled = v.busy || (!v.br && needs_loaded_value(v));
                if (!v.busy && !v.br && !needs_loaded_value(v) && v.id_halt) m_drain_left = 3;
            end
            if (stalled && m_stall < CNT_MAX) m_stall++;
        end
    endfunction

    task automatic apply(input in_t v);
        reset = v.reset; id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_uses_rs1 = v.id_u1;
        id_uses_rs2 = v.id_u2; id_halt = v.id_halt; ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2;
        ex_reg_wrenable = v.ex_we; ex_mem_to_reg = v.ex_load; ex_write_reg = v.ex_wr;
        ex_branch_taken = v.br; mem_reg_wrenable = v.mem_we; mem_write_reg = v.mem_wr;
        wb_reg_wrenable = v.wb_we; wb_write_reg = v.wb_wr; mem_busy = v.busy;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input out_t exp, input out_t mask, input in_t v);
        out_t act;
        act = {pc_enable, ifid_enable, ifid_flush, idex_enable, idex_bubble, pipe_enable,
               fwd_a_sel, fwd_b_sel, halted};
        n_checks++;
        if ((act & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s: outputs {pc,ife,ifl,ide,bub,pipe,fa,fb,hlt} got %b required %b (mask %b)",
                     name, act, exp, mask);
        end
        check_val({name, " stall_cycles"}, int'(stall_cycles), v.reset ? 0 : m_stall);
    endtask

    // One cycle: drive at negedge, check mid-cycle, advance model at posedge.
    task automatic step(input in_t v, input string name);
        @(negedge clk);
        apply(v);
        #1;
        check_out(name, model_out(v), model_mask(v), v);
        @(posedge clk);
        model_update(v);
    endtask

    task automatic do_reset();
        in_t v = idle();
        v.reset = 1'b1;
        step(v, "reset");
        step(v, "reset_hold");
    endtask

    vec_t tv[14];
    in_t  v;
    int   first;

    initial begin
        apply(idle());

        for (int i = 0; i < 14; i++) tv[i].in = idle();
        tv[0].name  = "idle";          tv[0].exp = mk(1, 1, 0, 1, 0, 1, 0, 0, 0);
        tv[1].name  = "lu_rs1";
        tv[1].in.ex_load = 1; tv[1].in.ex_we = 1; tv[1].in.ex_wr = 5; tv[1].in.id_rs1 = 5; tv[1].in.id_u1 = 1;
        tv[1].exp = mk(0, 0, 0, 1, 1, 1, 0, 0, 0);
        tv[2].name  = "lu_rs2";
        tv[2].in.ex_load = 1; tv[2].in.ex_we = 1; tv[2].in.ex_wr = 9; tv[2].in.id_rs2 = 9; tv[2].in.id_u2 = 1;
        tv[2].exp = mk(0, 0, 0, 1, 1, 1, 0, 0, 0);
        tv[3].name  = "rs2_unused";
        tv[3].in.ex_load = 1; tv[3].in.ex_we = 1; tv[3].in.ex_wr = 9; tv[3].in.id_rs2 = 9;
        tv[3].exp = mk(1, 1, 0, 1, 0, 1, 0, 0, 0);
        tv[4].name  = "load_r0";
        tv[4].in.ex_load = 1; tv[4].in.ex_we = 1; tv[4].in.ex_wr = 0; tv[4].in.id_u1 = 1;
        tv[4].exp = mk(1, 1, 0, 1, 0, 1, 0, 0, 0);
        tv[5].name  = "alu_dep";
        tv[5].in.ex_we = 1; tv[5].in.ex_wr = 5; tv[5].in.id_rs1 = 5; tv[5].in.id_u1 = 1;
        tv[5].exp = mk(1, 1, 0, 1, 0, 1, 0, 0, 0);
        tv[6].name  = "br_halt";       tv[6].in.br = 1; tv[6].in.id_halt = 1;
        tv[6].exp = mk(1, 1, 1, 1, 1, 1, 0, 0, 0);
        tv[7].name  = "after_br_halt"; tv[7].exp = mk(1, 1, 0, 1, 0, 1, 0, 0, 0);
        tv[8].name  = "br_lu";         tv[8].in = tv[1].in; tv[8].in.br = 1;
        tv[8].exp = mk(1, 1, 1, 1, 1, 1, 0, 0, 0);
        tv[9].name  = "busy_br";       tv[9].in.busy = 1; tv[9].in.br = 1; tv[9].in.id_halt = 1;
        tv[9].exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tv[10].name = "fwd_r3_both";
        tv[10].in.mem_we = 1; tv[10].in.mem_wr = 3; tv[10].in.wb_we = 1; tv[10].in.wb_wr = 3;
        tv[10].in.ex_rs2 = 3; tv[10].in.ex_rs1 = 3;
        tv[10].exp = mk(1, 1, 0, 1, 0, 1, 1, 1, 0);
        tv[11].name = "fwd_r0";
        tv[11].in.mem_we = 1; tv[11].in.wb_we = 1;
        tv[11].exp = mk(1, 1, 0, 1, 0, 1, 0, 0, 0);
        tv[12].name = "fwd_wb_only";
        tv[12].in.mem_wr = 4; tv[12].in.wb_we = 1; tv[12].in.wb_wr = 4; tv[12].in.ex_rs1 = 4;
        tv[12].exp = mk(1, 1, 0, 1, 0, 1, 2, 0, 0);
        tv[13].name = "fwd_mix";
        tv[13].in.mem_we = 1; tv[13].in.mem_wr = 6; tv[13].in.ex_rs2 = 6;
        tv[13].in.wb_we = 1; tv[13].in.wb_wr = 7; tv[13].in.ex_rs1 = 7;
        tv[13].exp = mk(1, 1, 0, 1, 0, 1, 2, 1, 0);

        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            apply(tv[i].in);
            #1;
            check_out(tv[i].name, tv[i].exp, '1, tv[i].in);
            @(posedge clk);
            model_update(tv[i].in);
        end

        // Load to r5 then dependent add: one stall cycle, then MEM forwarding.
        do_reset();
        step(tv[1].in, "lu_seq_stall");
        v = idle(); v.mem_we = 1; v.mem_wr = 5; v.ex_rs1 = 5; v.ex_we = 1; v.ex_wr = 6;
        step(v, "lu_seq_fwd");
        check_val("lu_seq_fwd_a", int'(fwd_a_sel), 1);
        check_val("lu_seq_stall_count", int'(stall_cycles), 1);

        // Halt accepted with one busy cycle inside the drain: halted five cycles later.
        do_reset();
        v = idle(); v.id_halt = 1;
        step(v, "halt_accept");
        first = 0;
        for (int t = 1; t <= 20 && first == 0; t++) begin
            v = idle(); v.busy = (t == 2);
            @(negedge clk);
            apply(v);
            #1;
            check_out("halt_drain", model_out(v), model_mask(v), v);
            if (halted) first = t;
            @(posedge clk);
            model_update(v);
        end
        check_val("halt_latency", first, 5);
        check_val("halt_stall_count", int'(stall_cycles), 1);
        step(idle(), "halted_hold");

        // Reset while halted.
        v = idle(); v.reset = 1;
        step(v, "reset_in_halted");
        check_val("reset_halted_flag", int'(halted), 0);
        check_val("reset_halted_stall", int'(stall_cycles), 0);
        step(idle(), "run_after_halted_reset");

        // Reset mid-drain.
        v = idle(); v.id_halt = 1;
        step(v, "halt_again");
        step(idle(), "drain_1");
        v = idle(); v.reset = 1;
        step(v, "reset_in_drain");
        step(idle(), "run_after_drain_reset");

        // mem_busy for four cycles.
        do_reset();
        v = idle(); v.busy = 1; v.br = 1; v.mem_we = 1; v.mem_wr = 2; v.ex_rs1 = 2;
        for (int i = 0; i < 4; i++) step(v, "busy4");
        step(idle(), "after_busy4");
        check_val("busy4_stall_count", int'(stall_cycles), 4);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            v.reset   = ($urandom_range(0, 39) == 0);
            v.id_rs1  = REG_W'($urandom_range(0, 3));
            v.id_rs2  = REG_W'($urandom_range(0, 3));
            v.id_u1   = 1'($urandom);
            v.id_u2   = 1'($urandom);
            v.id_halt = ($urandom_range(0, 15) == 0);
            v.ex_rs1  = REG_W'($urandom_range(0, 3));
            v.ex_rs2  = REG_W'($urandom_range(0, 3));
            v.ex_we   = 1'($urandom);
            v.ex_load = 1'($urandom);
            v.ex_wr   = REG_W'($urandom_range(0, 3));
            v.br      = ($urandom_range(0, 5) == 0);
            v.mem_we  = 1'($urandom);
            v.mem_wr  = REG_W'($urandom_range(0, 3));
            v.wb_we   = 1'($urandom);
            v.wb_wr   = REG_W'($urandom_range(0, 3));
            v.busy    = ($urandom_range(0, 5) == 0);
            step(v, "random");
        end

        // Saturation of the stall counter.
        do_reset();
        v = idle(); v.busy = 1;
        @(negedge clk);
        apply(v);
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            @(posedge clk);
            model_update(v);
        end
        step(v, "saturated");
        check_val("stall_saturated", int'(stall_cycles), CNT_MAX);
        step(v, "saturated_hold");
        check_val("stall_saturated_hold", int'(stall_cycles), CNT_MAX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
